mem_cmd_responder: RTL
======================

MEM_CMD_RESPONDER -- requirements
Module: mem_cmd_responder

Interface
REQ-001 SHALL have parameter AddrWidth, default 23: command address width.
REQ-002 SHALL have parameter DataWidth, default 16: data word width.
REQ-003 SHALL have parameter MemAddrWidth, default 10: backing-store index width (1024 words).
REQ-004 SHALL have parameter ReadLatency, default 3: cycles from read acceptance to cmdReadDataValid; legal range 1..8.
REQ-005 SHALL have parameter InitCycles, default 8: cycles with cmdReady low after reset.
REQ-006 SHALL have parameter RefreshInterval, default 64: cycles between refresh stalls.
REQ-007 SHALL have parameter RefreshCycles, default 4: length of each refresh stall.
REQ-008 SHALL have port clk, input, 1: clock.
REQ-009 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-010 SHALL have port cmdTrigger, input, 1: initiator presents a command.
REQ-011 SHALL have port cmdAddr, input, AddrWidth: word address.
REQ-012 SHALL have port cmdWrite, input, 1: 1 = write, 0 = read.
REQ-013 SHALL have port cmdWriteData, input, DataWidth: write data.
REQ-014 SHALL have port cmdReady, output, 1: command accepted this cycle if cmdTrigger high.
REQ-015 SHALL have port cmdReadData, output, DataWidth: read return data.
REQ-016 SHALL have port cmdReadDataValid, output, 1: cmdReadData valid, one cycle per read.

Function
REQ-017 SHALL accept a command on exactly the cycles where cmdTrigger && cmdReady at the rising edge of clk; there are no other acceptance conditions.
REQ-018 SHALL implement states INIT, READY, REFRESH:
  - INIT -> READY after InitCycles cycles.
  - READY -> REFRESH when the refresh counter reaches RefreshInterval-1.
  - REFRESH -> READY after RefreshCycles cycles.
REQ-019 SHALL drive cmdReady high only in READY, registered, so it is deasserted on the first cycle of INIT or REFRESH.
REQ-020 SHALL reset the refresh counter to 0 on entry to READY and count only in READY.
REQ-021 SHALL map backing-store index to cmdAddr[MemAddrWidth-1:0]; upper address bits are ignored (aliasing).
REQ-022 SHALL commit an accepted write to the store at the acceptance edge.
REQ-023 SHALL return data for an accepted read on cmdReadDataValid exactly ReadLatency cycles after acceptance.
REQ-024 SHALL sample read data at the acceptance edge, so a read accepted the cycle after a write to the same index returns the new data.
REQ-025 SHALL support back-to-back reads at one per cycle, returned in acceptance order, with no gaps beyond those in the acceptance sequence.
REQ-026 SHALL continue to advance and deliver in-flight reads during REFRESH.
REQ-027 SHALL hold cmdReadData at its last value when cmdReadDataValid is low.
REQ-028 SHALL leave store contents undefined after power-up and unchanged by rst.

Reset
REQ-029 SHALL, while rst is high, drive cmdReady=0, cmdReadDataValid=0, cmdReadData=0, state=INIT, and init/refresh counters=0.
REQ-030 SHALL discard all in-flight reads on rst, including rst asserted mid-pipeline, so no cmdReadDataValid follows reset.

Structure
REQ-031 SHALL place the state enum (INIT/READY/REFRESH) and the default AddrWidth/DataWidth constants in the shared memory-interface package also used by the controller and test harnesses.
REQ-032 SHALL implement the read-return path as one sub-module, mem_cmd_read_pipe: a valid+data shift register of depth ReadLatency with synchronous clear.

Verification
REQ-033 Reset: release rst, hold cmdTrigger=1 -> cmdReady low for exactly 8 cycles, then high; no cmdReadDataValid.
REQ-034 Write then read: write 0xA5C3 to addr 0x000005, then read 0x000005 the next cycle -> cmdReadDataValid 3 cycles after the read acceptance, cmdReadData=0xA5C3.
REQ-035 Aliasing: write 0x1234 to 0x000401, then read 0x000001 -> returns 0x1234.
REQ-036 Streaming: 10 back-to-back reads of addrs 0..9, previously written with ~addr -> 10 consecutive valid cycles carrying 0xFFFF..0xFFF6, in order.
REQ-037 Refresh: after 64 READY cycles -> cmdReady low for 4 cycles, then high. A read accepted 1 cycle before the stall still returns at latency 3.
REQ-038 Reset mid-flight: assert rst 1 cycle after a read acceptance -> no cmdReadDataValid at any later cycle; re-enter INIT.

Source files
------------

// File: rtl/mem_cmd_responder_pkg.sv
// ============================================================================
//  mem_cmd_responder_pkg
//  Shared memory-interface types and defaults for controller, responder and
//  test harnesses.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mem_cmd_responder_pkg;

    localparam int DEFAULT_ADDR_WIDTH     = 23;
    localparam int DEFAULT_DATA_WIDTH     = 16;
    localparam int DEFAULT_MEM_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_READY   = 2'd1,
        ST_REFRESH = 2'd2
    } mem_state_e;

    // Bits needed to hold a counter that runs 0 .. max_count-1.
    function automatic int count_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_cmd_read_pipe.sv
// ============================================================================
//  mem_cmd_read_pipe
//  Fixed-latency valid+data shift register carrying read returns.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_cmd_read_pipe #(
    parameter int DataWidth = 16,
    parameter int Depth     = 3
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [DataWidth-1:0] in_data,
    output logic                 out_valid,
    output logic [DataWidth-1:0] out_data
);

    logic                 valid_q [Depth];
    logic [DataWidth-1:0] data_q  [Depth];

    // Data only moves with a valid, so the last stage holds between returns.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < Depth; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[Depth-1];
    assign out_data  = data_q[Depth-1];

endmodule

`default_nettype wire

// File: rtl/mem_cmd_responder.sv
// ============================================================================
//  mem_cmd_responder
//  Word-addressed command responder with init/refresh stalls and a
//  fixed-latency read return path.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_cmd_responder
    import mem_cmd_responder_pkg::*;
#(
    parameter int AddrWidth       = DEFAULT_ADDR_WIDTH,
    parameter int DataWidth       = DEFAULT_DATA_WIDTH,
    parameter int MemAddrWidth    = DEFAULT_MEM_ADDR_WIDTH,
    parameter int ReadLatency     = 3,
    parameter int InitCycles      = 8,
    parameter int RefreshInterval = 64,
    parameter int RefreshCycles   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmdTrigger,
    input  logic [AddrWidth-1:0] cmdAddr,
    input  logic                 cmdWrite,
    input  logic [DataWidth-1:0] cmdWriteData,
    output logic                 cmdReady,
    output logic [DataWidth-1:0] cmdReadData,
    output logic                 cmdReadDataValid
);

    localparam int PHASE_MAX = (InitCycles > RefreshCycles) ? InitCycles : RefreshCycles;
    localparam int PHASE_W   = count_width(PHASE_MAX);
    localparam int REFRESH_W = count_width(RefreshInterval);

    localparam logic [PHASE_W-1:0]   INIT_LAST     = PHASE_W'(InitCycles - 1);
    localparam logic [PHASE_W-1:0]   REFRESH_LAST  = PHASE_W'(RefreshCycles - 1);
    localparam logic [PHASE_W-1:0]   PHASE_ONE     = PHASE_W'(1);
    localparam logic [REFRESH_W-1:0] INTERVAL_LAST = REFRESH_W'(RefreshInterval - 1);
    localparam logic [REFRESH_W-1:0] INTERVAL_ONE  = REFRESH_W'(1);

    mem_state_e           state;
    logic [PHASE_W-1:0]   phase_cnt;
    logic [REFRESH_W-1:0] refresh_cnt;
    logic                 ready_q;

    // phase_cnt times both the INIT and REFRESH stalls; refresh_cnt runs in READY only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            phase_cnt   <= '0;
            refresh_cnt <= '0;
            ready_q     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (phase_cnt == INIT_LAST) begin
                        state       <= ST_READY;
                        phase_cnt   <= '0;
                        refresh_cnt <= '0;
                        ready_q     <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_ONE;
                    end
                end
                ST_READY: begin
                    if (refresh_cnt == INTERVAL_LAST) begin
                        state     <= ST_REFRESH;
                        phase_cnt <= '0;
                        ready_q   <= 1'b0;
                    end else begin
                        refresh_cnt <= refresh_cnt + INTERVAL_ONE;
                    end
                end
                ST_REFRESH: begin
                    if (phase_cnt == REFRESH_LAST) begin
                        state       <= ST_READY;
                        phase_cnt   <= '0;
                        refresh_cnt <= '0;
                        ready_q     <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_ONE;
                    end
                end
                default: begin
                    state       <= ST_INIT;
                    phase_cnt   <= '0;
                    refresh_cnt <= '0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign cmdReady = ready_q;

    logic                    accept;
    logic [MemAddrWidth-1:0] mem_index;
    logic [DataWidth-1:0]    store [2**MemAddrWidth];
    logic                    unused_addr_bits;

    // Upper address bits alias onto the same store word.
    assign accept           = cmdTrigger && ready_q && !rst;
    assign mem_index        = cmdAddr[MemAddrWidth-1:0];
    assign unused_addr_bits = ^cmdAddr;

    always_ff @(posedge clk) begin
        if (accept && cmdWrite) begin
            store[mem_index] <= cmdWriteData;
        end
    end

    mem_cmd_read_pipe #(
        .DataWidth (DataWidth),
        .Depth     (ReadLatency)
    ) u_read_pipe (
        .clk       (clk),
        .clear     (rst),
        .in_valid  (accept && !cmdWrite),
        .in_data   (store[mem_index]),
        .out_valid (cmdReadDataValid),
        .out_data  (cmdReadData)
    );

endmodule

`default_nettype wire
